// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared size/state encodings and the alignment rule
package dmem_responder_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == SIZE_HALF && a[0]) || (size == SIZE_WORD && a != 2'b00) || size == 2'b11;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM with byte-lane write enables and registered read
module dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // lane-masked write and registered read; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with wait states, decode and error reporting
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_wen_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [1:0]  mem_wsize_i,
  input  logic [3:0]  mem_wmask_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q, wdata_q, hold_q, offset, arr_rdata;
  logic [1:0]  size_q;
  logic [3:0]  mask_q;
  logic        wen_q, err_c, go, load_ok;
  assign offset  = addr_q - BASE_ADDR;
  assign err_c   = misaligned(size_q, addr_q[1:0]) || ({1'b0, offset} >= LIMIT);
  assign go      = state_q == ST_WAIT && cnt_q == 4'd0;
  assign load_ok = !wen_q && !err_c;
  assign mem_ack_o   = state_q == ST_ACK;
  assign mem_err_o   = mem_ack_o && err_c;
  assign busy_o      = state_q != ST_IDLE;
  assign mem_rdata_o = mem_ack_o ? (load_ok ? arr_rdata : 32'd0) : hold_q;
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .re    (go && load_ok),
    .we    ((go && wen_q && !err_c) ? mask_q : 4'b0000),
    .addr  (offset[AW+1:2]),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );
  // state register; reset drops any uncommitted access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else state_q <= state_d;
  end
  // IDLE -> WAIT on request, WAIT -> ACK when the counter expires, ACK -> IDLE always
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) state_d = mem_req_i ? ST_WAIT : ST_IDLE;
    else if (state_q == ST_WAIT) state_d = cnt_q == 4'd0 ? ST_ACK : ST_WAIT;
    else state_d = ST_IDLE;
  end
  // request capture and wait-state countdown
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= SIZE_BYTE;
      mask_q  <= 4'd0;
      wen_q   <= 1'b0;
    end else if (state_q == ST_IDLE && mem_req_i) begin
      cnt_q   <= 4'(WAIT_CYCLES);
      addr_q  <= mem_addr_i;
      wdata_q <= mem_wdata_i;
      size_q  <= mem_wsize_i;
      mask_q  <= mem_wmask_i;
      wen_q   <= mem_wen_i;
    end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end
  // keep the last ACK's read word visible until the next ACK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= 32'd0;
    else if (mem_ack_o) hold_q <= mem_rdata_o;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of the responder with 1 and 0 wait states
module tb_dmem_responder;
  logic clk = 0, rst = 1;
  logic req = 0, wen = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [1:0] size = 0;
  logic [3:0] mask = 0;
  logic [31:0] rdata;
  logic ack, err, busy;
  logic b_req = 0, b_wen = 0;
  logic [31:0] b_addr = 0, b_wdata = 0;
  logic [1:0] b_size = 2'b10;
  logic [3:0] b_mask = 4'hf;
  logic [31:0] b_rdata;
  logic b_ack, b_err, b_busy;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .mem_req_i(req), .mem_wen_i(wen), .mem_addr_i(addr),
    .mem_wdata_i(wdata), .mem_wsize_i(size), .mem_wmask_i(mask),
    .mem_rdata_o(rdata), .mem_ack_o(ack), .mem_err_o(err), .busy_o(busy)
  );
  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .rst(rst), .mem_req_i(b_req), .mem_wen_i(b_wen), .mem_addr_i(b_addr),
    .mem_wdata_i(b_wdata), .mem_wsize_i(b_size), .mem_wmask_i(b_mask),
    .mem_rdata_o(b_rdata), .mem_ack_o(b_ack), .mem_err_o(b_err), .busy_o(b_busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic [3:0] m,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req = 1; wen = w; addr = a; wdata = d; size = sz; mask = m; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ack && lat < 20);
    if (!ack) chk("ack_timeout", 0, 1);
    rd = rdata; er = err;
    @(negedge clk);
    req = 0;
  endtask
  logic [31:0] rd, d1, d2;
  logic er;
  int lat, na, c1, c2;
  initial begin
    repeat (3) @(posedge clk);
    #1 chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    @(negedge clk) rst = 0;
    #1 chk("rel_rdata", rdata, 0);
    chk("rel_ack", ack, 0);
    chk("rel_err", err, 0);
    chk("rel_busy", busy, 0);
    txn(1, 32'h10, 32'h11111111, 2'b10, 4'hf, rd, er, lat);
    txn(1, 32'h8, 32'hDEADBEEF, 2'b10, 4'hf, rd, er, lat);
    chk("sw_lat", lat, 3);
    chk("sw_err", er, 0);
    txn(0, 32'h8, 0, 2'b10, 4'h0, rd, er, lat);
    chk("lw_lat", lat, 3);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", er, 0);
    @(posedge clk); #1;
    chk("ack_pulse", ack, 0);
    chk("rdata_hold", rdata, 32'hDEADBEEF);
    txn(1, 32'hA, 32'h00AA0000, 2'b00, 4'b0100, rd, er, lat);
    chk("sb_rdata0", rd, 0);
    chk("sb_err", er, 0);
    txn(0, 32'h8, 0, 2'b10, 4'h0, rd, er, lat);
    chk("sb_lw", rd, 32'hDEAABEEF);
    txn(1, 32'hA, 32'h12340000, 2'b01, 4'b1100, rd, er, lat);
    txn(0, 32'h8, 0, 2'b10, 4'h0, rd, er, lat);
    chk("sh_lw", rd, 32'h1234BEEF);
    txn(1, 32'h8, 32'hFFFFFFFF, 2'b10, 4'b0000, rd, er, lat);
    chk("mask0_err", er, 0);
    txn(0, 32'h8, 0, 2'b10, 4'h0, rd, er, lat);
    chk("mask0_lw", rd, 32'h1234BEEF);
    txn(1, 32'h4, 32'hCAFEF00D, 2'b10, 4'hf, rd, er, lat);
    txn(1, 32'h6, 32'h11112222, 2'b10, 4'hf, rd, er, lat);
    chk("mis_sw_err", er, 1);
    chk("mis_sw_rdata", rd, 0);
    txn(1, 32'h5, 32'h00777700, 2'b01, 4'b0110, rd, er, lat);
    chk("mis_sh_err", er, 1);
    txn(1, 32'h4, 32'h99999999, 2'b11, 4'hf, rd, er, lat);
    chk("size3_err", er, 1);
    txn(0, 32'h4, 0, 2'b10, 4'h0, rd, er, lat);
    chk("mis_lw", rd, 32'hCAFEF00D);
    chk("mis_lw_err", er, 0);
    txn(1, 32'h0, 32'h01020304, 2'b10, 4'hf, rd, er, lat);
    txn(0, 32'h1000, 0, 2'b10, 4'h0, rd, er, lat);
    chk("oor_lw_err", er, 1);
    chk("oor_lw_rdata", rd, 0);
    txn(1, 32'h1000, 32'h5A5A5A5A, 2'b10, 4'hf, rd, er, lat);
    chk("oor_sw_err", er, 1);
    txn(0, 32'hFFFFFFFC, 0, 2'b10, 4'h0, rd, er, lat);
    chk("wrap_err", er, 1);
    txn(0, 32'h0, 0, 2'b10, 4'h0, rd, er, lat);
    chk("oor_lw0", rd, 32'h01020304);
    @(negedge clk);
    req = 1; wen = 1; addr = 32'h10; wdata = 32'h22222222; size = 2'b10; mask = 4'hf;
    @(posedge clk); #1;
    chk("midwait_busy", busy, 1);
    rst = 1;
    #1 chk("midrst_busy", busy, 0);
    @(negedge clk) req = 0;
    @(negedge clk) rst = 0;
    txn(0, 32'h10, 0, 2'b10, 4'h0, rd, er, lat);
    chk("rst_drop", rd, 32'h11111111);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b_req = 1; b_wen = 1; b_addr = 32'(k * 4); b_wdata = k == 0 ? 32'hA5A5A5A5 : 32'h3C3C3C3C;
      lat = 0;
      do begin
        @(posedge clk); #1; lat++;
      end while (!b_ack && lat < 10);
      if (!b_ack) chk("b_ack_timeout", 0, 1);
      @(negedge clk) b_req = 0;
    end
    @(negedge clk);
    b_req = 1; b_wen = 0; b_addr = 32'h0;
    na = 0; c1 = 0; c2 = 0; d1 = 0; d2 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (b_ack) begin
        na++;
        if (na == 1) begin c1 = i; d1 = b_rdata; end
        else if (na == 2) begin c2 = i; d2 = b_rdata; end
      end
      @(negedge clk);
      if (na == 1 && c1 == i) b_addr = 32'h4;
      if (na >= 2) b_req = 0;
    end
    chk("b2b_count", na, 2);
    chk("b2b_first", c1, 2);
    chk("b2b_second", c2, 5);
    chk("b2b_d0", d1, 32'hA5A5A5A5);
    chk("b2b_d4", d2, 32'h3C3C3C3C);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the execution unit's load/store memory interface.
- Accepts one request at a time (address, write data, size, byte mask, write enable) and services it against an internal word-organised data RAM after a configurable number of wait states.
- Returns an aligned 32-bit read word plus a single-cycle ack, which releases the core's load/store hold.
- Sits between the core's execution stage and on-chip data storage.

Parameters:
- DEPTH, 1024, number of 32-bit words in the data RAM (power of two).
- WAIT_CYCLES, 1, wait states between request capture and ack (0..15).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mem_req_i  input  1  request valid; held stable by requester until ack.
- mem_wen_i  input  1  1 = store, 0 = load.
- mem_addr_i  input  32  byte address.
- mem_wdata_i  input  32  store data, already lane-positioned.
- mem_wsize_i  input  2  00 byte, 01 half, 10 word.
- mem_wmask_i  input  4  byte-lane write enables, bit n = bits [8n+7:8n].
- mem_rdata_o  output  32  aligned word read; valid while mem_ack_o=1.
- mem_ack_o  output  1  one-cycle completion pulse.
- mem_err_o  output  1  asserted with ack when the request was rejected.
- busy_o  output  1  transaction in progress (state != IDLE).

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE and the wait counter to 0.
  - mem_rdata_o=0, mem_ack_o=0, mem_err_o=0, busy_o=0.
  - RAM contents are not cleared.
- IDLE:
  - If mem_req_i=1 on a rising edge, capture addr, wdata, wsize, wmask and wen into registers, load the wait counter with WAIT_CYCLES, and go to WAIT.
  - While in IDLE the request inputs are ignored except on that capture edge.
- WAIT:
  - The counter decrements each cycle.
  - With WAIT_CYCLES=0, WAIT lasts exactly one cycle.
  - On the edge where the counter is 0, go to ACK and perform the RAM access:
    - Store: write the lanes selected by the captured mask.
    - Load: latch the RAM word into mem_rdata_o.
- ACK: mem_ack_o=1 for exactly one cycle, then back to IDLE unconditionally.
- Latency: request edge to ack-high is WAIT_CYCLES+2 edges (default: ack is high in the 3rd cycle after the request is first seen).
- Back-to-back: mem_req_i still high in the cycle after ACK is a new transaction. No request is ever serviced twice within one ACK.
- Address decode:
  - offset = addr - BASE_ADDR; word index = offset[log2(DEPTH)+1:2].
  - offset >= 4*DEPTH (unsigned, including wrap below BASE_ADDR) is out of range: no write, mem_rdata_o=0, mem_err_o=1 in ACK.
- Alignment check, on captured wsize/addr:
  - Half with addr[0]=1, or word with addr[1:0]!=0: error, no write, rdata=0, mem_err_o=1.
  - wsize=11: error.
  - Bytes are always aligned.
- Store mask:
  - Only mask bits govern which lanes are written; wsize is used only for the alignment check.
  - Mask 0000 on a store is a legal no-op write, err=0.
- Loads:
  - Return the full 32-bit word regardless of wsize; lane selection and sign extension belong to the requester.
  - mem_rdata_o holds its value until the next load's ACK, or becomes 0 on a store/error ACK.
- mem_err_o is only ever high together with mem_ack_o.
- Reset mid-transaction: a store not yet committed (state WAIT) is dropped; no partial lane writes.
- Read-after-write: a load issued after a store's ack returns the stored data.

Decomposition:
- Shared header (alongside define.v):
  - wsize encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - responder state encodings ST_IDLE/ST_WAIT/ST_ACK.
- One sub-module: dmem_array.
  - DEPTH x 32 storage with 4-lane byte-enable synchronous write and synchronous read (registered output) on one port.
  - dmem_responder holds the FSM, counter, decode and error logic.

Test Plan:
- Reset held 3 cycles, released -> all outputs 0, busy_o=0; assert rst mid-WAIT of a store to 0x10 -> subsequent load of 0x10 returns the prior value.
- WAIT_CYCLES=1, SW addr 0x8 wdata 0xDEADBEEF mask 1111, then LW 0x8 -> store ack 3 cycles after req; load rdata 0xDEADBEEF, err=0.
- Byte/half lanes after SW 0x8=0xDEADBEEF:
  - SB mask 0100 wdata 0x00AA0000 -> LW 0x8 = 0xDEAABEEF.
  - SH mask 1100 wdata 0x12340000 -> LW 0x8 = 0x1234BEEF.
- Misaligned SW 0x6 and SH 0x5 -> ack with err=1, rdata=0, RAM word at 0x4 unchanged.
- Out of range with DEPTH=1024: LW 0x1000 -> rdata 0, err=1; SW 0x1000 -> no RAM word changes.
- mem_req_i held high across two LW (0x0 then 0x4) with WAIT_CYCLES=0 -> exactly two ack pulses separated by 2 idle-or-wait cycles, each with correct data.
